// File: rtl/rv_pc_gen_if.sv
// Fetch PC generator bundle: stall, branch resolution from execute,
// and the predicted fetch stream back to the front end.
interface rv_pc_gen_if #(
    parameter int IADDR_SPACE_BITS = 32
);
    logic                        i_stall;
    logic                        i_br_valid;
    logic                        i_br_is_branch;
    logic                        i_br_is_jump;
    logic                        i_br_no_alloc;
    logic                        i_br_taken;
    logic [IADDR_SPACE_BITS-1:0] i_br_pc;
    logic [IADDR_SPACE_BITS-1:0] i_br_pc_next;
    logic [IADDR_SPACE_BITS-1:0] i_br_target;
    logic [IADDR_SPACE_BITS-1:0] o_pc;
    logic [IADDR_SPACE_BITS-1:0] o_pc_next;
    logic                        o_branch_pred;
    logic                        o_flush;

    modport master (
        output i_stall,
        output i_br_valid,
        output i_br_is_branch,
        output i_br_is_jump,
        output i_br_no_alloc,
        output i_br_taken,
        output i_br_pc,
        output i_br_pc_next,
        output i_br_target,
        input  o_pc,
        input  o_pc_next,
        input  o_branch_pred,
        input  o_flush
    );

    modport slave (
        input  i_stall,
        input  i_br_valid,
        input  i_br_is_branch,
        input  i_br_is_jump,
        input  i_br_no_alloc,
        input  i_br_taken,
        input  i_br_pc,
        input  i_br_pc_next,
        input  i_br_target,
        output o_pc,
        output o_pc_next,
        output o_branch_pred,
        output o_flush
    );
endinterface

// File: rtl/rv_pc_gen.sv
// Fetch PC generator with a direct-mapped BTB of 2-bit counters;
// redirects on resolved mispredictions and trains from execute.
module rv_pc_gen #(
    parameter int                          IADDR_SPACE_BITS = 32,
    parameter logic [IADDR_SPACE_BITS-1:0] RESET_ADDR       = '0,
    parameter int                          BTB_IDX_BITS     = 4
) (
    input logic        i_clk,
    input logic        i_reset,
    rv_pc_gen_if.slave bus
);
    localparam int AW = IADDR_SPACE_BITS;
    localparam int NE = 1 << BTB_IDX_BITS;
    localparam int TW = AW - BTB_IDX_BITS - 2;
    localparam logic [AW-1:0] FOUR = AW'(4);
    localparam logic [AW-1:0] ONE  = AW'(1);

    logic [AW-1:0] pc_q;
    logic [NE-1:0] vld_q;
    logic [TW-1:0] tag_q [NE];
    logic [AW-1:0] tgt_q [NE];
    logic [1:0]    ctr_q [NE];

    logic [BTB_IDX_BITS-1:0] f_idx;
    logic [BTB_IDX_BITS-1:0] b_idx;
    logic [TW-1:0]           b_tag;
    logic                    f_hit;
    logic                    f_pred;
    logic                    b_hit;
    logic [AW-1:0]           pc_pred;
    logic [AW-1:0]           tgt_al;
    logic [AW-1:0]           act_next;
    logic                    flush;
    logic                    train;
    logic                    wr_en;
    logic [AW-1:0]           wr_tgt;
    logic [1:0]              wr_ctr;

    // Fetch-side lookup reads the arrays asynchronously
    assign f_idx   = pc_q[BTB_IDX_BITS+1:2];
    assign f_hit   = vld_q[f_idx]
                   && (tag_q[f_idx] == pc_q[AW-1:BTB_IDX_BITS+2]);
    assign f_pred  = f_hit && ctr_q[f_idx][1];
    assign pc_pred = f_pred ? tgt_q[f_idx] : pc_q + FOUR;

    assign tgt_al   = bus.i_br_target & ~ONE;
    assign act_next = bus.i_br_taken ? tgt_al
                                     : bus.i_br_pc + FOUR;
    assign flush    = !i_reset && bus.i_br_valid
                   && (act_next != bus.i_br_pc_next);
    assign train    = bus.i_br_valid && !bus.i_br_no_alloc;

    assign b_idx = bus.i_br_pc[BTB_IDX_BITS+1:2];
    assign b_tag = bus.i_br_pc[AW-1:BTB_IDX_BITS+2];
    assign b_hit = vld_q[b_idx] && (tag_q[b_idx] == b_tag);

    always_comb begin
        wr_en  = 1'b0;
        wr_tgt = tgt_al;
        wr_ctr = ctr_q[b_idx];
        if (train) begin
            unique case (1'b1)
                bus.i_br_is_jump: begin
                    wr_en  = 1'b1;
                    wr_ctr = 2'd3;
                end
                bus.i_br_is_branch && b_hit: begin
                    wr_en = 1'b1;
                    if (bus.i_br_taken) begin
                        wr_ctr = (ctr_q[b_idx] == 2'd3) ? 2'd3
                               : ctr_q[b_idx] + 2'd1;
                    end else begin
                        wr_tgt = tgt_q[b_idx];
                        wr_ctr = (ctr_q[b_idx] == 2'd0) ? 2'd0
                               : ctr_q[b_idx] - 2'd1;
                    end
                end
                bus.i_br_is_branch && !b_hit && bus.i_br_taken: begin
                    wr_en  = 1'b1;
                    wr_ctr = 2'd2;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            pc_q  <= RESET_ADDR;
            vld_q <= '0;
        end else begin
            if (flush) begin
                pc_q <= act_next;
            end else if (!bus.i_stall) begin
                pc_q <= pc_pred;
            end
            if (wr_en) begin
                vld_q[b_idx] <= 1'b1;
            end
        end
    end

    // Payload needs no reset: it is only read behind a valid bit
    always_ff @(posedge i_clk) begin
        if (!i_reset && wr_en) begin
            tag_q[b_idx] <= b_tag;
            tgt_q[b_idx] <= wr_tgt;
            ctr_q[b_idx] <= wr_ctr;
        end
    end

    assign bus.o_pc          = pc_q;
    assign bus.o_pc_next     = pc_pred;
    assign bus.o_branch_pred = f_pred;
    assign bus.o_flush       = flush;
endmodule
